uart_alu_engine: RTL and testbench
==================================

// Module: uart_alu_engine
// PURPOSE
//  Byte-stream packet ALU between the UART RX and TX byte interfaces. Parses a
//  4-byte header (opcode, reserved, length LSB, length MSB). Then either echoes
//  the payload, or reduces it as little-endian operands (add / multiply) and
//  returns one result. Generalises the ECHO-only engine: operand width is
//  parametrised, both ports have full valid/ready backpressure, and it uses a
//  sequential multiplier.
// PARAMETERS
//  OPERAND_BYTES  4   bytes per operand/result; W = 8*OPERAND_BYTES
//  LENGTH_BITS    16  width of packet length field/counter (header carries 16; upper bits zero)
// PORTS
//  clk_i    in   1  clock
//  reset_i  in   1  asynchronous, active-high reset
//  valid_i  in   1  RX byte valid
//  data_i   in   8  RX byte
//  ready_o  out  1  engine accepts data_i this cycle
//  ready_i  in   1  TX consumer ready
//  data_o   out  8  TX byte
//  valid_o  out  1  data_o valid
// BEHAVIOUR
//  - One clock, clk_i. reset_i is asynchronous and active-high. Reset clears the
//    FSM, all registers and all outputs: valid_o=0, data_o=0, ready_o=1 (Idle).
//  - Accept = valid_i&ready_o. Transfer = valid_o&ready_i. valid_o/data_o are held
//    stable until Transfer.
//  - Length = total packet bytes including the 4 header bytes. Payload P=len-4; len<4 => P=0.
//  - States / transitions (advance on Accept unless noted):
//    IDLE: opcode in {ECHO 0xEC, ADD 0xAD, MUL 0x63} -> RSVD, latch opcode.
//      Any other byte is dropped; stay IDLE.
//    RSVD: byte ignored -> LEN_LSB.  LEN_LSB: latch len[7:0] -> LEN_MSB.
//    LEN_MSB: latch len[15:8]; clear byte/operand counters and acc.
//      P=0: ECHO -> IDLE; ADD/MUL -> RESULT (acc=0).
//      Otherwise ECHO -> ECHO_PL; ADD/MUL -> LOAD.
//    ECHO_PL: 1-entry output reg. ready_o = ~valid_o | ready_i. Accepted byte
//      appears on data_o next cycle. After the P-th byte is accepted -> ECHO_DRAIN.
//    ECHO_DRAIN: ready_o=0; after the last byte's Transfer -> IDLE.
//    LOAD: ready_o=1. Shift bytes LSB-first into operand reg.
//      The operand completes on byte OPERAND_BYTES, or on the last payload byte.
//      A partial trailing operand is zero-extended.
//      On completion:
//        ADD: acc <= acc + opnd (mod 2^W), same cycle.
//        MUL, first operand: acc <= opnd.
//        MUL, later operand: start multiplier -> MUL_RUN.
//      After the last payload byte: ADD/first-only MUL -> RESULT; else MUL_RUN.
//    MUL_RUN: ready_o=0. Multiplier takes exactly W cycles. Then acc <= low W bits
//      of the product. Next state: LOAD if payload remains, else RESULT.
//    RESULT: ready_o=0. Emit acc as OPERAND_BYTES bytes, LSB first, one per
//      Transfer; valid_o is asserted the cycle after entry. After the last Transfer -> IDLE.
//  - ready_o=1 in IDLE, RSVD, LEN_LSB, LEN_MSB, LOAD; 0 in MUL_RUN, RESULT, ECHO_DRAIN.
//  - valid_o is never asserted outside ECHO_PL, ECHO_DRAIN, RESULT.
//  - Byte counter is LENGTH_BITS wide; it compares against P and never wraps
//    within a packet (P <= 2^16-5).
//  - ready_i deasserted indefinitely: hold all state; no byte lost or duplicated.
//  - valid_i while ready_o=0: byte not consumed; upstream holds it.
//  - Reset asserted mid-packet: immediate return to IDLE. Partial packet discarded;
//    in-flight output dropped (valid_o=0 while reset asserted).
// STRUCTURE
//  - Package uart_alu_pkg: opcode constants OP_ECHO=8'hEC, OP_ADD=8'hAD,
//    OP_MUL=8'h63; state enum alu_state_e; HDR_BYTES=4.
//  - Sub-module uart_alu_mul #(W): shift-add multiplier.
//    Ports: start, a, b, busy, done (1-cycle pulse), p[W-1:0].
//    Latency W cycles start->done; ignores start while busy.
//  - Engine: FSM, length/byte counters, operand shift reg, accumulator, output reg.
// TESTING
//  - ECHO: EC 00 07 00 41 42 43, ready_i=1 -> out 41 42 43, each 1 cycle after accept; then IDLE.
//  - ADD: AD 00 0C 00 01 00 00 00 02 00 00 00 -> out 03 00 00 00.
//  - ADD wrap: AD 00 0C 00 FF FF FF FF 01 00 00 00 -> out 00 00 00 00.
//  - MUL: 63 00 0C 00 03 00 00 00 05 00 00 00 -> ready_o low 32 cycles, out 0F 00 00 00.
//  - Partial/empty: AD 00 06 00 34 12 -> out 34 12 00 00; 63 00 04 00 -> out 00 00 00 00.
//  - Unknown + backpressure: 99, then EC 00 06 00 AA BB with ready_i low 10 cycles
//    -> 99 dropped; ready_o=0 while AA is held; AA BB delivered in order; none lost.
//  - Reset mid-packet: reset during MUL_RUN -> valid_o=0, ready_o=1;
//    next EC 00 05 00 5A -> out 5A.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART packet ALU engine.
package uart_alu_pkg;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_MUL  = 8'h63;

   // Header: opcode, reserved, length LSB, length MSB.
   localparam int HDR_BYTES = 4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RSVD,
      ST_LEN_LSB,
      ST_LEN_MSB,
      ST_ECHO_PL,
      ST_ECHO_DRAIN,
      ST_LOAD,
      ST_MUL_RUN,
      ST_RESULT
   } alu_state_e;

   // True for the three opcodes that start a packet; anything else is noise.
   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_ECHO) || (b == OP_ADD) || (b == OP_MUL);
   endfunction

endpackage

// File: rtl/uart_alu_if.sv
// Byte-stream handshake bundle between the UART side and the ALU engine.
// Signal names are from the engine's point of view (_i into it, _o out of it).
interface uart_alu_if;

   logic       valid_i;   // RX byte valid
   logic [7:0] data_i;    // RX byte
   logic       ready_o;   // engine accepts data_i this cycle
   logic       ready_i;   // TX consumer ready
   logic [7:0] data_o;    // TX byte
   logic       valid_o;   // data_o valid

   modport master (
      output valid_i, data_i, ready_i,
      input  ready_o, data_o, valid_o
   );

   modport slave (
      input  valid_i, data_i, ready_i,
      output ready_o, data_o, valid_o
   );

endinterface

// File: rtl/uart_alu_mul.sv
// Sequential shift-add multiplier, low W bits of a*b.
// Bit 0 of the multiplier is consumed on the start edge itself so that done
// is high in the W-th cycle after start and the result can be taken on the
// following edge, giving the caller a W-cycle busy window.
module uart_alu_mul #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] p_o
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  prod_q,   prod_d;
   logic [W-1:0]  mcand_q,  mcand_d;
   logic [W-1:0]  mplier_q, mplier_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic          busy_q,   busy_d;
   logic          done_q,   done_d;

   // Next-state: load on start when idle, otherwise one add/shift step per cycle.
   always_comb begin
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (!busy_q) begin
         if (start_i) begin
            prod_d   = b_i[0] ? a_i : '0;
            mcand_d  = a_i << 1;
            mplier_d = b_i >> 1;
            cnt_d    = CW'(W - 1);
            busy_d   = 1'b1;
         end
      end else begin
         if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign p_o    = prod_q;

endmodule

// File: rtl/uart_alu_engine.sv
// Byte-stream packet ALU: parses a 4-byte header, then echoes the payload or
// reduces it as little-endian operands (add / multiply) and returns one result.
module uart_alu_engine
   import uart_alu_pkg::*;
#(
   parameter int OPERAND_BYTES = 4,
   parameter int LENGTH_BITS   = 16
) (
   input  logic     clk_i,
   input  logic     reset_i,
   uart_alu_if.slave bus
);

   localparam int W     = 8 * OPERAND_BYTES;
   localparam int IDX_W = $clog2(OPERAND_BYTES + 1);

   alu_state_e             state_q,     state_d;
   logic [7:0]             opcode_q,    opcode_d;
   logic [7:0]             len_lo_q,    len_lo_d;
   logic [LENGTH_BITS-1:0] pay_q,       pay_d;
   logic [LENGTH_BITS-1:0] byte_cnt_q,  byte_cnt_d;
   logic [W-1:0]           opnd_q,      opnd_d;
   logic [IDX_W-1:0]       opnd_idx_q,  opnd_idx_d;
   logic                   first_q,     first_d;
   logic [W-1:0]           acc_q,       acc_d;
   logic [IDX_W-1:0]       res_idx_q,   res_idx_d;
   logic [7:0]             out_data_q,  out_data_d;
   logic                   out_valid_q, out_valid_d;

   logic                   ready;
   logic                   accept;
   logic                   transfer;
   logic [LENGTH_BITS-1:0] len_full;
   logic [LENGTH_BITS-1:0] pay_len;
   logic [LENGTH_BITS-1:0] byte_cnt_inc;
   logic                   last_byte;
   logic [W-1:0]           opnd_new;
   logic                   opnd_done;
   logic [7:0]             res_byte;
   logic                   mul_start;
   logic                   mul_go;
   logic                   mul_busy;
   logic                   mul_done;
   logic [W-1:0]           mul_p;

   // Input is only throttled while an output byte is pending or the multiplier runs.
   always_comb begin
      ready = 1'b0;
      case (state_q)
         ST_IDLE, ST_RSVD, ST_LEN_LSB, ST_LEN_MSB, ST_LOAD: ready = 1'b1;
         ST_ECHO_PL: ready = ~out_valid_q | bus.ready_i;
         default:    ready = 1'b0;
      endcase
   end

   assign accept   = bus.valid_i & ready;
   assign transfer = out_valid_q & bus.ready_i;

   // Header length includes the header itself; shorter lengths mean no payload.
   assign len_full = LENGTH_BITS'({bus.data_i, len_lo_q});
   assign pay_len  = (len_full >= LENGTH_BITS'(HDR_BYTES)) ?
                     (len_full - LENGTH_BITS'(HDR_BYTES)) : '0;

   assign byte_cnt_inc = byte_cnt_q + 1'b1;
   assign last_byte    = (byte_cnt_inc == pay_q);

   // Bytes land at their little-endian position; unfilled bytes stay zero,
   // which zero-extends a short trailing operand.
   assign opnd_new  = opnd_q | (W'(bus.data_i) << {opnd_idx_q, 3'b000});
   assign opnd_done = (opnd_idx_q == IDX_W'(OPERAND_BYTES - 1)) || last_byte;

   assign res_byte  = acc_q[{res_idx_q, 3'b000} +: 8];

   assign mul_go    = mul_start & ~mul_busy;

   uart_alu_mul #(.W(W)) u_mul (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (mul_go),
      .a_i     (acc_q),
      .b_i     (opnd_new),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .p_o     (mul_p)
   );

   // Next-state and datapath updates for the packet FSM.
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      len_lo_d    = len_lo_q;
      pay_d       = pay_q;
      byte_cnt_d  = byte_cnt_q;
      opnd_d      = opnd_q;
      opnd_idx_d  = opnd_idx_q;
      first_d     = first_q;
      acc_d       = acc_q;
      res_idx_d   = res_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      mul_start   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept && is_opcode(bus.data_i)) begin
               opcode_d = bus.data_i;
               state_d  = ST_RSVD;
            end
         end

         ST_RSVD: begin
            if (accept) state_d = ST_LEN_LSB;
         end

         ST_LEN_LSB: begin
            if (accept) begin
               len_lo_d = bus.data_i;
               state_d  = ST_LEN_MSB;
            end
         end

         ST_LEN_MSB: begin
            if (accept) begin
               pay_d      = pay_len;
               byte_cnt_d = '0;
               opnd_d     = '0;
               opnd_idx_d = '0;
               acc_d      = '0;
               first_d    = 1'b1;
               res_idx_d  = '0;
               if (pay_len == '0) begin
                  state_d = (opcode_q == OP_ECHO) ? ST_IDLE : ST_RESULT;
               end else begin
                  state_d = (opcode_q == OP_ECHO) ? ST_ECHO_PL : ST_LOAD;
               end
            end
         end

         ST_ECHO_PL: begin
            if (accept) begin
               out_data_d  = bus.data_i;
               out_valid_d = 1'b1;
               byte_cnt_d  = byte_cnt_inc;
               if (last_byte) state_d = ST_ECHO_DRAIN;
            end else if (transfer) begin
               out_valid_d = 1'b0;
            end
         end

         ST_ECHO_DRAIN: begin
            if (transfer) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         ST_LOAD: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_inc;
               opnd_d     = opnd_new;
               opnd_idx_d = opnd_idx_q + 1'b1;
               if (opnd_done) begin
                  opnd_d     = '0;
                  opnd_idx_d = '0;
                  if (opcode_q == OP_ADD) begin
                     acc_d = acc_q + opnd_new;
                     if (last_byte) state_d = ST_RESULT;
                  end else if (first_q) begin
                     acc_d   = opnd_new;
                     first_d = 1'b0;
                     if (last_byte) state_d = ST_RESULT;
                  end else begin
                     mul_start = 1'b1;
                     state_d   = ST_MUL_RUN;
                  end
               end
            end
         end

         ST_MUL_RUN: begin
            if (mul_done) begin
               acc_d   = mul_p;
               state_d = (byte_cnt_q == pay_q) ? ST_RESULT : ST_LOAD;
            end
         end

         ST_RESULT: begin
            // res_idx counts bytes already loaded into the output register.
            if (transfer) begin
               if (res_idx_q == IDX_W'(OPERAND_BYTES)) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  out_data_d = res_byte;
                  res_idx_d  = res_idx_q + 1'b1;
               end
            end else if (!out_valid_q) begin
               out_data_d  = res_byte;
               out_valid_d = 1'b1;
               res_idx_d   = res_idx_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any packet in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         len_lo_q    <= '0;
         pay_q       <= '0;
         byte_cnt_q  <= '0;
         opnd_q      <= '0;
         opnd_idx_q  <= '0;
         first_q     <= 1'b0;
         acc_q       <= '0;
         res_idx_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         len_lo_q    <= len_lo_d;
         pay_q       <= pay_d;
         byte_cnt_q  <= byte_cnt_d;
         opnd_q      <= opnd_d;
         opnd_idx_q  <= opnd_idx_d;
         first_q     <= first_d;
         acc_q       <= acc_d;
         res_idx_q   <= res_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.ready_o = ready;
   assign bus.data_o  = out_data_q;
   assign bus.valid_o = out_valid_q;

endmodule

// File: tb/tb_uart_alu_engine.sv
// Scoreboard bench for uart_alu_engine: directed packets plus randomized
// traffic, expected bytes from a packet-level reference model.
module tb_uart_alu_engine;
   import uart_alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_alu_if bus();

   uart_alu_engine #(.OPERAND_BYTES(4), .LENGTH_BITS(16)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s got %0h want %0h", name, act, want);
      end else begin
         $display("[TB] check %s = %0h ok", name, act);
      end
   endtask

   // Packet-level reference: echo payload, or fold 32-bit little-endian operands.
   task automatic model(input logic [7:0] pkt[$]);
      logic [7:0]      op;
      int              len, p, nops;
      longint unsigned acc, opnd;
      longint unsigned mask = 64'hFFFF_FFFF;
      op = pkt[0];
      if (!is_opcode(op)) return;
      len = int'({pkt[3], pkt[2]});
      p   = (len < 4) ? 0 : len - 4;
      if (op == OP_ECHO) begin
         for (int i = 0; i < p; i++) exp_q.push_back(pkt[4 + i]);
      end else begin
         nops = (p + 3) / 4;
         acc  = 0;
         for (int k = 0; k < nops; k++) begin
            opnd = 0;
            for (int j = 0; j < 4; j++)
               if (4 * k + j < p) opnd |= longint'(pkt[4 + 4 * k + j]) << (8 * j);
            if (op == OP_ADD)  acc = (acc + opnd) & mask;
            else if (k == 0)   acc = opnd;
            else               acc = (acc * opnd) & mask;
         end
         for (int j = 0; j < 4; j++) exp_q.push_back(8'(acc >> (8 * j)));
      end
   endtask

   // Starts and ends just after a falling edge; holds the byte until accepted.
   task automatic send_byte(input logic [7:0] b);
      int   guard = 0;
      logic acc;
      bus.valid_i = 1'b1;
      bus.data_i  = b;
      forever begin
         #1;
         acc = bus.ready_o;
         @(negedge clk);
         if (acc) break;
         guard++;
         if (guard > 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout got stalled want accept byte %02h", b);
            break;
         end
      end
      bus.valid_i = 1'b0;
   endtask

   task automatic send_packet(input logic [7:0] pkt[$]);
      model(pkt);
      foreach (pkt[i]) send_byte(pkt[i]);
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((exp_q.size() != 0 || bus.valid_o) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   // Consumer ready generator.
   initial begin
      bus.ready_i = 1'b1;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       bus.ready_i = 1'b1;
            1:       bus.ready_i = ($urandom_range(0, 3) != 0);
            default: bus.ready_i = 1'b0;
         endcase
      end
   end

   // Monitor: every output transfer is compared against the scoreboard head.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.valid_o && bus.ready_i) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL out_unexpected got %02h want none", bus.data_o);
            end else begin
               e = exp_q.pop_front();
               if (bus.data_o !== e) begin
                  fails++;
                  $display("FAIL out_byte got %02h want %02h", bus.data_o, e);
               end else begin
                  $display("[TB] out byte %02h ok", bus.data_o);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] pkt[$];
      logic [7:0] b;
      int         cnt, guard, p, len, sel;

      bus.valid_i = 1'b0;
      bus.data_i  = 8'h00;

      repeat (3) @(negedge clk);
      #1;
      check("reset_valid_o", bus.valid_o, 0);
      check("reset_data_o",  bus.data_o,  0);
      check("reset_ready_o", bus.ready_o, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed packets with an always-ready consumer.
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      send_packet(pkt);
      wait_drain();
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      send_packet(pkt);
      wait_drain();
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
      send_packet(pkt);
      wait_drain();

      // MUL: the multiplier keeps ready_o low for 32 cycles, then RESULT spends
      // one cycle loading the first byte before valid_o rises: 33 idle cycles.
      pkt = '{8'h63, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_packet(pkt);
      cnt = 0;
      guard = 0;
      while (guard < 200) begin
         #1;
         if (bus.valid_o) break;
         if (!bus.ready_o) cnt++;
         @(negedge clk);
         guard++;
      end
      check("mul_ready_low_cycles", cnt, 33);
      @(negedge clk);
      wait_drain();

      pkt = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
      send_packet(pkt);
      wait_drain();
      pkt = '{8'h63, 8'h00, 8'h04, 8'h00};
      send_packet(pkt);
      wait_drain();

      // Unknown opcode then echo under a stalled consumer.
      ready_mode = 2;
      @(negedge clk);
      pkt = '{8'h99};
      send_packet(pkt);
      pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      model(pkt);
      for (int i = 0; i < 5; i++) send_byte(pkt[i]);
      bus.valid_i = 1'b1;
      bus.data_i  = 8'hBB;
      repeat (10) @(negedge clk);
      #1;
      check("stall_ready_o", bus.ready_o, 0);
      check("stall_valid_o", bus.valid_o, 1);
      check("stall_data_o",  bus.data_o,  8'hAA);
      @(negedge clk);
      ready_mode = 0;
      send_byte(8'hBB);
      wait_drain();

      // Reset while the multiplier is running: nothing from that packet is expected.
      pkt = '{8'h63, 8'h00, 8'h0C, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
      foreach (pkt[i]) send_byte(pkt[i]);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_valid_o", bus.valid_o, 0);
      check("midrst_ready_o", bus.ready_o, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
      send_packet(pkt);
      wait_drain();

      // Randomized traffic with a random consumer.
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            do b = 8'($urandom); while (is_opcode(b));
            pkt = '{b};
            send_packet(pkt);
         end
         sel = $urandom_range(0, 2);
         p   = $urandom_range(0, 10);
         len = (p == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : p + 4;
         pkt.delete();
         pkt.push_back(sel == 0 ? OP_ECHO : (sel == 1 ? OP_ADD : OP_MUL));
         pkt.push_back(8'($urandom));
         pkt.push_back(8'(len));
         pkt.push_back(8'(len >> 8));
         for (int i = 0; i < p; i++) pkt.push_back(8'($urandom));
         send_packet(pkt);
      end
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
